rx_port_arbiter: RTL and testbench
==================================

# rx_port_arbiter

Packet-granular round-robin arbiter that merges the AXI4-Stream outputs of NUM_PORTS per-port RX queues into a single 64-bit stream toward the output pipeline. It sits in the core `clk` domain, downstream of the MAC-to-AXI RX converters. It never splits a packet and never reorders beats within a port. It keeps per-port forwarded-packet counters for the register block.

## Interface
Parameters:
- NUM_PORTS, 4, number of input streams (2..8)
- AXI_DATA_WIDTH, 64, data width (only 64 supported)
- CNT_WIDTH, 32, width of each packet counter

Ports (clk, reset first):
- clk  in  1  core clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- s_tdata  in  NUM_PORTS*64  input data, port i at bits [64*i+63:64*i]
- s_tstrb  in  NUM_PORTS*8  input byte strobes, port i at [8*i+7:8*i]
- s_tvalid  in  NUM_PORTS  per-port valid
- s_tlast  in  NUM_PORTS  per-port end of packet
- s_tready  out  NUM_PORTS  per-port ready
- m_tdata  out  64  output data
- m_tstrb  out  8  output strobes
- m_tvalid  out  1  output valid
- m_tlast  out  1  output end of packet
- m_tready  in  1  downstream ready
- grant  out  NUM_PORTS  one-hot current owner; 0 when idle
- pkt_count  out  NUM_PORTS*CNT_WIDTH  forwarded packets per port, port i at [CNT_WIDTH*i+CNT_WIDTH-1:CNT_WIDTH*i]

## Operation
- Registered state: `state` (IDLE, BUSY), `grant_idx` (log2 NUM_PORTS bits), `rr_ptr` (log2 NUM_PORTS bits), and the counters.
- **IDLE:**
  - All `s_tready` are 0. `m_tvalid`, `m_tlast`, `m_tdata`, `m_tstrb` and `grant` are 0.
  - If any `s_tvalid` is set, the arbiter picks the first asserted port searching cyclically from `rr_ptr` (rr_ptr, rr_ptr+1, … mod NUM_PORTS).
  - It latches that port into `grant_idx` and moves to BUSY. No beat is transferred in this cycle.
- **BUSY:**
  - `m_tdata`, `m_tstrb`, `m_tvalid` and `m_tlast` equal the granted port's inputs, combinationally.
  - `s_tready[grant_idx]` equals `m_tready`. All other `s_tready` are 0.
  - `grant` is one-hot of `grant_idx`.
  - On a beat with m_tvalid & m_tready & m_tlast:
    - `pkt_count[grant_idx]` increments by 1, wrapping from all-ones to 0.
    - `rr_ptr` becomes (grant_idx+1) mod NUM_PORTS.
    - State returns to IDLE.
  - While BUSY, other ports' `s_tvalid` is ignored. Ownership is held until `tlast`, however long the granted port stalls with `s_tvalid` = 0.
- A beat with `tstrb` = 0 is forwarded unchanged. The arbiter does not inspect strobes.
- **Reset** (any cycle, including mid-packet):
  - State goes to IDLE; `grant_idx` = 0, `rr_ptr` = 0, all counters = 0.
  - All outputs read 0 in the following cycle.
  - Any partially forwarded packet is truncated downstream. The remainder of that packet is treated as a new packet by the next arbitration, and upstream blocks are reset together with this one.

## Timing
- Arbitration costs exactly one bubble cycle per packet:
  - a packet whose first beat is valid in cycle N (arbiter IDLE) can present that beat on m_* in cycle N+1 at the earliest;
  - back-to-back packets give at most one idle output cycle between one packet's `tlast` beat and the next packet's first beat.
- The data path is combinational while BUSY: zero-cycle latency from s_* to m_*, and from `m_tready` to `s_tready`.
- The grant decision uses `s_tvalid` sampled in IDLE only. A port that deasserts `s_tvalid` after being granted simply stalls the output.
- Counter update, `rr_ptr` update and the return to IDLE all take effect on the clock edge that completes the `tlast` handshake.
- Fairness: with all ports continuously valid, grants rotate 0,1,…,NUM_PORTS-1,0,…

## Test plan
- **Reset/idle:** hold reset 3 cycles with all s_tvalid=1 -> s_tready=0, m_tvalid=0, grant=0, every pkt_count=0 during reset and in the first cycle after.
- **Single port:** port 2 sends a 3-beat packet (data 0xA0..0xA2, last strb 0x0F), m_tready=1 -> m_* shows the 3 beats in consecutive cycles starting 1 cycle after s_tvalid rises; grant=4'b0100; pkt_count[2]=1; rr_ptr=3.
- **Round-robin:** all 4 ports continuously offer 2-beat packets -> output owner sequence 0,1,2,3,0,1; exactly 1 idle cycle between packets; each pkt_count increments once per round.
- **Backpressure and stall:** toggle m_tready 1/0 every cycle and drop the granted port's s_tvalid for 2 mid-packet cycles while port 1 is valid -> no beat lost or duplicated; port 1 is not granted until the granted packet's tlast handshake.
- **Simultaneous requests:** rr_ptr=3 with ports 1 and 2 valid in the same cycle -> port 1 granted (cyclic order 3,0,1).
- **Reset mid-packet plus counter wrap:** assert reset after beat 2 of a 5-beat packet -> outputs 0 next cycle, rr_ptr=0. Separately, with CNT_WIDTH=4, forward 16 packets on port 0 -> pkt_count[0] returns to 0.

Source files
------------

// File: rtl/rx_port_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS AXI4-Stream RX queues into a
// single 64-bit stream, with a forwarded-packet counter per port.
module rx_port_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_PORTS*AXI_DATA_WIDTH-1:0]     s_tdata,
  input  logic [NUM_PORTS*(AXI_DATA_WIDTH/8)-1:0] s_tstrb,
  input  logic [NUM_PORTS-1:0]                   s_tvalid,
  input  logic [NUM_PORTS-1:0]                   s_tlast,
  output logic [NUM_PORTS-1:0]                   s_tready,
  output logic [AXI_DATA_WIDTH-1:0]              m_tdata,
  output logic [AXI_DATA_WIDTH/8-1:0]            m_tstrb,
  output logic                                   m_tvalid,
  output logic                                   m_tlast,
  input  logic                                   m_tready,
  output logic [NUM_PORTS-1:0]                   grant,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]         pkt_count
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [IDX_W:0]   PORTS_EXT = (IDX_W + 1)'(NUM_PORTS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PORTS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                   state, state_next;
  logic [IDX_W-1:0]         grant_idx, grant_idx_next;
  logic [IDX_W-1:0]         rr_ptr, rr_ptr_next;
  logic [CNT_WIDTH-1:0]     cnt [NUM_PORTS];
  logic [AXI_DATA_WIDTH-1:0] port_data [NUM_PORTS];
  logic [STRB_W-1:0]        port_strb [NUM_PORTS];
  logic [IDX_W:0]           cand;
  logic [IDX_W-1:0]         pick_idx;
  logic                     pick_found;
  logic                     done;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign port_data[i] = s_tdata[AXI_DATA_WIDTH*i +: AXI_DATA_WIDTH];
    assign port_strb[i] = s_tstrb[STRB_W*i +: STRB_W];
    assign pkt_count[CNT_WIDTH*i +: CNT_WIDTH] = cnt[i];
  end

  // Completing handshake of the granted packet's last beat.
  assign done = (state == BUSY) && s_tvalid[grant_idx] && m_tready && s_tlast[grant_idx];

  // Cyclic search from rr_ptr; scanning offsets downward lets the smallest offset win.
  always_comb begin
    cand       = '0;
    pick_idx   = rr_ptr;
    pick_found = 1'b0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      cand = (cand >= PORTS_EXT) ? (cand - PORTS_EXT) : cand;
      pick_idx   = s_tvalid[cand[IDX_W-1:0]] ? cand[IDX_W-1:0] : pick_idx;
      pick_found = pick_found | s_tvalid[cand[IDX_W-1:0]];
    end
  end

  // Next-state logic: grant in IDLE, release on the tlast handshake.
  always_comb begin
    state_next     = state;
    grant_idx_next = grant_idx;
    rr_ptr_next    = rr_ptr;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_next     = BUSY;
          grant_idx_next = pick_idx;
        end else begin
          state_next = IDLE;
        end
      end
      BUSY: begin
        if (done) begin
          state_next  = IDLE;
          rr_ptr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
        end else begin
          state_next = BUSY;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Combinational data path from the granted port while BUSY; all zero when IDLE.
  always_comb begin
    m_tdata  = '0;
    m_tstrb  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    grant    = '0;
    if (state == BUSY) begin
      m_tdata             = port_data[grant_idx];
      m_tstrb             = port_strb[grant_idx];
      m_tvalid            = s_tvalid[grant_idx];
      m_tlast             = s_tlast[grant_idx];
      s_tready[grant_idx] = m_tready;
      grant[grant_idx]    = 1'b1;
    end else begin
      grant = '0;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_next;
      grant_idx <= grant_idx_next;
      rr_ptr    <= rr_ptr_next;
    end
  end

  // Per-port packet counters; wrap naturally at all-ones.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (reset) begin
        cnt[i] <= '0;
      end else if (done && (grant_idx == IDX_W'(i))) begin
        cnt[i] <= cnt[i] + CNT_WIDTH'(1);
      end else begin
        cnt[i] <= cnt[i];
      end
    end
  end

endmodule

// File: tb/tb_rx_port_arbiter.sv
// Self-checking bench for rx_port_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a packet-level reference model.
module tb_rx_port_arbiter;

  localparam int N  = 4;
  localparam int CW = 32;
  localparam int WW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*64-1:0] s_tdata;
  logic [N*8-1:0]  s_tstrb;
  logic [N-1:0]    s_tvalid, s_tlast, s_tready, s_tready_w;
  logic [63:0]     m_tdata, m_tdata_w;
  logic [7:0]      m_tstrb, m_tstrb_w;
  logic            m_tvalid, m_tlast, m_tvalid_w, m_tlast_w;
  logic            m_tready;
  logic [N-1:0]    grant, grant_w;
  logic [N*CW-1:0] pkt_count;
  logic [N*WW-1:0] pkt_count_w;

  always #5 clk = ~clk;

  rx_port_arbiter #(.NUM_PORTS(N), .AXI_DATA_WIDTH(64), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .s_tdata(s_tdata), .s_tstrb(s_tstrb),
    .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready), .grant(grant), .pkt_count(pkt_count));

  // Narrow-counter instance sharing the same stimulus, used to observe wrap.
  rx_port_arbiter #(.NUM_PORTS(N), .AXI_DATA_WIDTH(64), .CNT_WIDTH(WW)) dut_w (
    .clk(clk), .reset(reset), .s_tdata(s_tdata), .s_tstrb(s_tstrb),
    .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready_w),
    .m_tdata(m_tdata_w), .m_tstrb(m_tstrb_w), .m_tvalid(m_tvalid_w), .m_tlast(m_tlast_w),
    .m_tready(m_tready), .grant(grant_w), .pkt_count(pkt_count_w));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- sources ----------------
  int          pkts_left [N];
  int          len [N];
  int          beat [N];
  logic [63:0] base [N];
  logic [7:0]  strb_last [N];
  bit          drop [N];
  bit          rnd_mode = 1'b0;
  bit          stall_mode = 1'b0;
  int          drops_done = 0;

  // output observation
  int          owners [$];
  int          gaps [$];
  logic [63:0] out_data [$];
  bit          out_first = 1'b1;
  int          idle_run = 0;

  function automatic int onehot_idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic new_pkt(input int i);
    len[i]       = $urandom_range(1, 6);
    base[i]      = {$urandom, $urandom};
    strb_last[i] = 8'($urandom);
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      s_tdata[64*i +: 64] = base[i] + 64'(beat[i]);
      s_tlast[i]          = (beat[i] == len[i] - 1);
      s_tstrb[8*i +: 8]   = (beat[i] == len[i] - 1) ? strb_last[i] : 8'hFF;
      s_tvalid[i]         = (pkts_left[i] > 0) && !drop[i];
    end
  endtask

  // Record this cycle, advance one clock, update sources, settle inputs.
  task automatic step();
    logic [N-1:0] fire;
    bit           rst_now;
    fire    = s_tvalid & s_tready;
    rst_now = reset;
    if (m_tvalid && m_tready) begin
      if (out_first) begin
        owners.push_back(onehot_idx(grant));
        gaps.push_back(idle_run);
      end
      out_data.push_back(m_tdata);
      out_first = m_tlast;
      idle_run  = 0;
    end else if (!m_tvalid) begin
      idle_run++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rst_now) begin
        beat[i] = 0;
      end else if (fire[i]) begin
        if (beat[i] == len[i] - 1) begin
          beat[i] = 0;
          if (pkts_left[i] > 0) pkts_left[i]--;
          if (rnd_mode) new_pkt(i);
        end else begin
          beat[i]++;
        end
      end
    end
    if (rnd_mode) begin
      m_tready = ($urandom_range(0, 2) != 0);
      reset    = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < N; i++) drop[i] = ($urandom_range(0, 3) == 0);
    end
    if (stall_mode) begin
      m_tready = ~m_tready;
      if (beat[0] == 2 && drops_done < 2) begin
        drop[0] = 1'b1;
        drops_done++;
      end else begin
        drop[0] = 1'b0;
      end
    end
    apply_inputs();
    #2;
  endtask

  task automatic clear_obs();
    owners.delete();
    gaps.delete();
    out_data.delete();
    out_first = 1'b1;
    idle_run  = 0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) begin
      pkts_left[i] = 0;
      drop[i]      = 1'b0;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // ---------------- reference model ----------------
  int          mo = -1;
  int          mnext = 0;
  int unsigned mcnt [N];
  bit          mok = 1'b0;
  logic [63:0] e_data;
  logic [9:0]  e_ctrl;
  logic [N-1:0] e_rdy, e_gnt;
  logic [N-1:0] one_n = 1;

  // Compare DUT outputs to the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    if (mok) begin
      if (mo < 0) begin
        e_data = '0;
        e_ctrl = '0;
        e_rdy  = '0;
        e_gnt  = '0;
      end else begin
        e_data = s_tdata[64*mo +: 64];
        e_ctrl = {s_tstrb[8*mo +: 8], s_tvalid[mo], s_tlast[mo]};
        e_gnt  = one_n << mo;
        e_rdy  = m_tready ? e_gnt : '0;
      end
      check("m_tdata", m_tdata, e_data);
      check("m_ctrl", {m_tstrb, m_tvalid, m_tlast}, e_ctrl);
      check("ready_grant", {s_tready, grant}, {e_rdy, e_gnt});
      check("wrap_ready_grant", {s_tready_w, grant_w}, {e_rdy, e_gnt});
      for (int i = 0; i < N; i++) begin
        check("pkt_count", pkt_count[CW*i +: CW], 64'(mcnt[i]));
        check("pkt_count_wrap", pkt_count_w[WW*i +: WW], 64'(mcnt[i] % 16));
      end
    end
    if (reset) begin
      mo = -1;
      mnext = 0;
      for (int i = 0; i < N; i++) mcnt[i] = 0;
      mok = 1'b1;
    end else if (mok) begin
      if (mo < 0) begin
        for (int k = 0; k < N; k++) begin
          if (mo < 0 && s_tvalid[(mnext + k) % N]) mo = (mnext + k) % N;
        end
      end else if (s_tvalid[mo] && m_tready && s_tlast[mo]) begin
        mcnt[mo]++;
        mnext = (mo + 1) % N;
        mo = -1;
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    reset    = 1'b1;
    m_tready = 1'b0;
    for (int i = 0; i < N; i++) begin
      pkts_left[i] = 100;
      len[i]       = 2;
      beat[i]      = 0;
      base[i]      = 64'h1000 * 64'(i);
      strb_last[i] = 8'hFF;
      drop[i]      = 1'b0;
    end
    apply_inputs();
    #2;

    // Reset held 3 cycles with every port valid, then one cycle after.
    for (int r = 0; r < 3; r++) begin
      if (r == 2) for (int i = 0; i < N; i++) pkts_left[i] = 0;
      step();
      if (r == 2) reset = 1'b0;
      check("rst_s_tready", s_tready, 64'h0);
      check("rst_m_tvalid", m_tvalid, 64'h0);
      check("rst_grant", grant, 64'h0);
      check("rst_pkt_count", pkt_count[63:0] | pkt_count[127:64], 64'h0);
    end

    // Single port 2, 3-beat packet.
    m_tready = 1'b1;
    pkts_left[2] = 1; len[2] = 3; base[2] = 64'hA0; strb_last[2] = 8'h0F;
    step();
    check("sp_bubble_valid", m_tvalid, 64'h0);
    for (int b = 0; b < 3; b++) begin
      step();
      check("sp_data", m_tdata, 64'hA0 + 64'(b));
      check("sp_grant", grant, 64'h4);
      check("sp_last", m_tlast, (b == 2) ? 64'h1 : 64'h0);
    end
    check("sp_last_strb", m_tstrb, 64'h0F);
    step();
    check("sp_count2", pkt_count[CW*2 +: CW], 64'h1);
    check("sp_idle_grant", grant, 64'h0);

    // rr_ptr is now 3: ports 1 and 2 together -> port 1 first.
    pkts_left[1] = 1; len[1] = 1; base[1] = 64'h11; strb_last[1] = 8'hFF;
    pkts_left[2] = 1; len[2] = 1; base[2] = 64'h22;
    step();
    step();
    check("sim_grant1", grant, 64'h2);
    check("sim_data1", m_tdata, 64'h11);
    step();
    step();
    check("sim_grant2", grant, 64'h4);
    step();

    // Round robin with every port continuously offering 2-beat packets.
    do_reset();
    for (int i = 0; i < N; i++) begin
      pkts_left[i] = 100; len[i] = 2; base[i] = 64'h100 * 64'(i + 1);
    end
    step();
    clear_obs();
    for (int c = 0; c < 12; c++) step();
    for (int i = 0; i < N; i++) check("rr_round1_count", pkt_count[CW*i +: CW], 64'h1);
    for (int c = 0; c < 6; c++) step();
    check("rr_owner_count", 64'(owners.size() >= 6), 64'h1);
    if (owners.size() >= 6) begin
      for (int k = 0; k < 6; k++) begin
        check("rr_owner", 64'(owners[k]), 64'(k % N));
        check("rr_gap", 64'(gaps[k]), 64'h1);
      end
    end

    // Backpressure toggling plus a 2-cycle source stall; port 1 waits for tlast.
    do_reset();
    pkts_left[0] = 1; len[0] = 4; base[0] = 64'hB0; strb_last[0] = 8'hFF;
    pkts_left[1] = 1; len[1] = 2; base[1] = 64'hC0; strb_last[1] = 8'h00;
    m_tready = 1'b1;
    drops_done = 0;
    stall_mode = 1'b1;
    step();
    clear_obs();
    for (int c = 0; c < 26; c++) begin
      check("no_early_grant1", 64'(grant[1] && (pkts_left[0] != 0)), 64'h0);
      step();
    end
    stall_mode = 1'b0;
    drop[0] = 1'b0;
    m_tready = 1'b1;
    check("bp_beats", 64'(out_data.size()), 64'd6);
    if (out_data.size() == 6) begin
      for (int k = 0; k < 6; k++)
        check("bp_data", out_data[k], (k < 4) ? 64'hB0 + 64'(k) : 64'hC0 + 64'(k - 4));
    end
    check("bp_owner_seq", {32'(owners.size()), 32'(owners.size() == 2 ? owners[0] * 16 + owners[1] : 0)},
          {32'd2, 32'h1});
    check("bp_count0", pkt_count[CW*0 +: CW], 64'h1);
    check("bp_count1", pkt_count[CW*1 +: CW], 64'h1);

    // Reset in the middle of a 5-beat packet on port 3 (rr_ptr is 2 here).
    pkts_left[3] = 1; len[3] = 5; base[3] = 64'hD0; strb_last[3] = 8'hFF;
    step();
    step();
    step();
    step();
    check("mid_beat3", m_tdata, 64'hD2);
    reset = 1'b1;
    pkts_left[1] = 1; len[1] = 1; base[1] = 64'hE1;
    step();
    reset = 1'b0;
    check("mid_rst_valid", m_tvalid, 64'h0);
    check("mid_rst_data", m_tdata, 64'h0);
    check("mid_rst_grant", grant, 64'h0);
    check("mid_rst_ready", s_tready, 64'h0);
    check("mid_rst_count", pkt_count[CW*1 +: CW], 64'h0);
    step();
    check("mid_rr_reset_grant", grant, 64'h2);
    for (int c = 0; c < 10; c++) step();

    // 16 single-beat packets on port 0: the 4-bit counter wraps to 0.
    do_reset();
    m_tready = 1'b1;
    pkts_left[0] = 16; len[0] = 1; base[0] = 64'hF0; strb_last[0] = 8'h00;
    for (int c = 0; c < 40; c++) step();
    check("wrap_wide_count", pkt_count[CW*0 +: CW], 64'd16);
    check("wrap_narrow_count", pkt_count_w[WW*0 +: WW], 64'h0);

    // Randomized traffic, stalls, backpressure and occasional reset.
    do_reset();
    for (int i = 0; i < N; i++) begin
      pkts_left[i] = 1000000;
      beat[i] = 0;
      new_pkt(i);
    end
    rnd_mode = 1'b1;
    for (int c = 0; c < 3000; c++) step();
    rnd_mode = 1'b0;
    reset = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
